// File: rtl/fpu_latch_pkg.sv
// Shared definitions for the latch-bank write controller: FSM encoding and counter sizing.
package fpu_latch_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_SETUP = 3'd1;
  localparam logic [STATE_W-1:0] S_PULSE = 3'd2;
  localparam logic [STATE_W-1:0] S_HOLD  = 3'd3;
  localparam logic [STATE_W-1:0] S_CLEAR = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_SETUP = S_SETUP,
    ST_PULSE = S_PULSE,
    ST_HOLD  = S_HOLD,
    ST_CLEAR = S_CLEAR
  } state_t;

  // The counter is loaded with (cycles - 1), so it only has to hold max-1.
  function automatic int cnt_width(input int en_cycles, input int hold_cycles);
    int m;
    m = (en_cycles > hold_cycles) ? en_cycles : hold_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/latch_en_decoder.sv
// Address to one-hot latch-enable decode with out-of-range flag; purely combinational.
// Out-of-range addresses give an all-zero vector so no cell can be written.
module latch_en_decoder #(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 3
) (
  input  logic [ADDR_W-1:0]    addr,
  output logic [NUM_WORDS-1:0] onehot,
  output logic                 oor
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (32'(addr) == i) onehot[i] = 1'b1;
    end
  end

  assign oor = (32'(addr) >= 32'(NUM_WORDS));

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Sequences d/en/rstn of a d_latch bank: setup, enable pulse, hold; write takes 3+EN+HOLD-1 cycles to done.
// Backpressure: req_ready is registered, high only in IDLE (including the done cycle).
module latch_bank_wr_ctrl
  import fpu_latch_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_WORDS   = 8,
  parameter int ADDR_W      = 3,
  parameter int EN_CYCLES   = 1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_clr,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_data,
  output logic [DATA_W-1:0]    latch_d,
  output logic [NUM_WORDS-1:0] latch_en,
  output logic                 latch_rstn,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_W = cnt_width(EN_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] EN_LOAD   = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [NUM_WORDS-1:0] sel_q, sel_nx, dec_onehot, en_nx;
  logic                 oor_q, oor_nx, dec_oor;
  logic [DATA_W-1:0]    d_nx;
  logic                 rstn_nx, ready_nx, busy_nx, done_nx, err_nx;
  logic                 accept;

  assign accept = req_valid && req_ready;

  latch_en_decoder #(
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_dec (
    .addr   (req_addr),
    .onehot (dec_onehot),
    .oor    (dec_oor)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Every output is computed one cycle ahead so the latch pins come straight from flops.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel_q;
    oor_nx   = oor_q;
    d_nx     = latch_d;
    en_nx    = '0;
    rstn_nx  = 1'b1;
    ready_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_clr) begin
            state_nx = ST_CLEAR;
            cnt_nx   = EN_LOAD;
            rstn_nx  = 1'b0;
          end else begin
            state_nx = ST_SETUP;
            d_nx     = req_data;
            sel_nx   = dec_onehot;
            oor_nx   = dec_oor;
          end
        end else begin
          ready_nx = 1'b1;
        end
      end
      ST_SETUP: begin
        state_nx = ST_PULSE;
        cnt_nx   = EN_LOAD;
        en_nx    = sel_q;
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LOAD;
        end else begin
          cnt_nx = cnt - 1'b1;
          en_nx  = sel_q;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nx = ST_IDLE;
          ready_nx = 1'b1;
          done_nx  = 1'b1;
          err_nx   = oor_q;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_CLEAR: begin
        if (cnt == '0) begin
          state_nx = ST_IDLE;
          ready_nx = 1'b1;
          done_nx  = 1'b1;
        end else begin
          cnt_nx  = cnt - 1'b1;
          rstn_nx = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  // Reset drives latch_rstn low so the bank is cleared for as long as rstn is held.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt        <= '0;
      sel_q      <= '0;
      oor_q      <= 1'b0;
      latch_d    <= '0;
      latch_en   <= '0;
      latch_rstn <= 1'b0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      sel_q      <= sel_nx;
      oor_q      <= oor_nx;
      latch_d    <= d_nx;
      latch_en   <= en_nx;
      latch_rstn <= rstn_nx;
      req_ready  <= ready_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Bench for latch_bank_wr_ctrl: two instances (EN/HOLD = 1/1 and 3/2) share one request stream
// and are compared every cycle against a timeline model derived from request acceptance times.
module tb_latch_bank_wr_ctrl;

  localparam int DW = 32;
  localparam int NW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          req_valid;
  logic          req_clr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;

  logic [1:0]    rdy, bsy, dn, er, lrst;
  logic [DW-1:0] ld  [2];
  logic [NW-1:0] len [2];

  latch_bank_wr_ctrl #(
    .DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW), .EN_CYCLES(1), .HOLD_CYCLES(1)
  ) u_dut_short (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_clr(req_clr), .req_addr(req_addr), .req_data(req_data),
    .latch_d(ld[0]), .latch_en(len[0]), .latch_rstn(lrst[0]),
    .busy(bsy[0]), .done(dn[0]), .err(er[0])
  );

  latch_bank_wr_ctrl #(
    .DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW), .EN_CYCLES(3), .HOLD_CYCLES(2)
  ) u_dut_long (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_clr(req_clr), .req_addr(req_addr), .req_data(req_data),
    .latch_d(ld[1]), .latch_en(len[1]), .latch_rstn(lrst[1]),
    .busy(bsy[1]), .done(dn[1]), .err(er[1])
  );

  int n_vec  = 0;
  int n_miss = 0;
  int edge_n = 0;

  // Reference model: per instance, the last accepted request and when it was taken.
  bit            m_have [2];
  int            m_acc  [2];
  bit            m_clr  [2];
  int            m_addr [2];
  logic [DW-1:0] m_d    [2];
  bit            m_rdy  [2];

  function automatic int en_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // One clock: decide acceptances from the model's ready, advance, then check both instances.
  task automatic step();
    bit            acc [2];
    bit            rst_edge;
    int            t, last, en_c, hold_c;
    logic [NW-1:0] e_en;
    bit            e_rst, e_busy, e_done, e_err, e_rdy;
    rst_edge = !rstn;
    for (int i = 0; i < 2; i++) acc[i] = rstn && req_valid && m_rdy[i];
    @(posedge clk);
    #1;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      en_c   = en_of(i);
      hold_c = hold_of(i);
      e_en   = '0;
      e_rst  = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_err  = 1'b0;
      e_rdy  = 1'b1;
      if (rst_edge) begin
        m_have[i] = 1'b0;
        m_d[i]    = '0;
        e_rst     = 1'b0;
        e_rdy     = 1'b0;
      end else begin
        if (acc[i]) begin
          m_have[i] = 1'b1;
          m_acc[i]  = edge_n;
          m_clr[i]  = req_clr;
          if (!req_clr) begin
            m_addr[i] = int'(req_addr);
            m_d[i]    = req_data;
          end
        end
        if (m_have[i]) begin
          // t = 1 is the first cycle after the accepting edge
          t    = edge_n - m_acc[i] + 1;
          last = m_clr[i] ? (1 + en_c) : (2 + en_c + hold_c);
          if (t < last) begin
            e_busy = 1'b1;
            e_rdy  = 1'b0;
            if (m_clr[i] && t <= en_c) e_rst = 1'b0;
            if (!m_clr[i] && t >= 2 && t <= 1 + en_c && m_addr[i] < NW)
              e_en = NW'(1) << m_addr[i];
          end else if (t == last) begin
            e_done = 1'b1;
            e_err  = !m_clr[i] && (m_addr[i] >= NW);
          end else begin
            m_have[i] = 1'b0;
          end
        end
      end
      m_rdy[i] = e_rdy;
      chk($sformatf("req_ready[%0d]", i),  64'(rdy[i]),  64'(e_rdy));
      chk($sformatf("busy[%0d]", i),       64'(bsy[i]),  64'(e_busy));
      chk($sformatf("done[%0d]", i),       64'(dn[i]),   64'(e_done));
      chk($sformatf("err[%0d]", i),        64'(er[i]),   64'(e_err));
      chk($sformatf("latch_rstn[%0d]", i), 64'(lrst[i]), 64'(e_rst));
      chk($sformatf("latch_en[%0d]", i),   64'(len[i]),  64'(e_en));
      chk($sformatf("latch_d[%0d]", i),    64'(ld[i]),   64'(m_d[i]));
      chk($sformatf("en_onehot[%0d]", i),  64'($countones(len[i]) <= 1), 64'(1));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Holds the request until the short instance takes it (bounded).
  task automatic send(input bit clr, input int addr, input logic [DW-1:0] data);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_clr   = clr;
    req_addr  = AW'(addr);
    req_data  = data;
    for (int n = 0; n < 40 && !ok; n++) begin
      ok = m_rdy[0];
      step();
    end
    chk("accept_wait", 64'(ok), 64'(1));
    req_valid = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_clr   = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 2; i++) begin
      m_have[i] = 1'b0;
      m_acc[i]  = 0;
      m_clr[i]  = 1'b0;
      m_addr[i] = 0;
      m_d[i]    = '0;
      m_rdy[i]  = 1'b0;
    end

    idle(3);
    rstn = 1'b1;
    idle(2);

    send(1'b0, 5, 32'hDEADBEEF);
    idle(10);

    send(1'b0, 1, $urandom);
    send(1'b0, 2, $urandom);
    idle(10);

    send(1'b0, 0, $urandom);
    idle(10);

    send(1'b0, 9, $urandom);
    idle(10);

    send(1'b1, 0, '0);
    idle(10);

    // Reset lands while both instances are in their enable pulse.
    send(1'b0, 3, $urandom);
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    idle(10);

    for (int n = 0; n < 600; n++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_clr   = ($urandom_range(0, 7) == 0);
      req_addr  = AW'($urandom_range(0, 15));
      req_data  = $urandom;
      rstn      = ($urandom_range(0, 149) != 0);
      step();
    end
    req_valid = 1'b0;
    rstn      = 1'b1;
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/latch_bank_wr_ctrl.md
# latch_bank_wr_ctrl

Upstream write controller for a bank of `d_latch` cells used as latch-based operand/register storage in the FPU. It accepts write and bulk-clear requests over a valid/ready handshake and sequences each latch's `d`, `en` and `rstn` pins. Each write follows a setup, enable-pulse, hold order, so data never changes while an enable is high. Every cell in the bank is driven directly from this block's registered outputs.

## Interface
- `DATA_W`, 32, width of each latch word
- `NUM_WORDS`, 8, number of latch words in the bank
- `ADDR_W`, 3, request address width
- `EN_CYCLES`, 1, enable-pulse length in clocks (≥1)
- `HOLD_CYCLES`, 1, data-hold length after enable falls (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: synchronous reset, active low
- `req_valid` in 1: request present
- `req_ready` out 1: block can accept; registered
- `req_clr` in 1: request is a bulk clear; `req_addr`/`req_data` are ignored
- `req_addr` in ADDR_W: target word
- `req_data` in DATA_W: write data
- `latch_d` out DATA_W: shared data bus to all latches
- `latch_en` out NUM_WORDS: one-hot or zero latch enables
- `latch_rstn` out 1: active-low bulk clear to the bank
- `busy` out 1: FSM not in IDLE
- `done` out 1: one-cycle completion pulse
- `err` out 1: out-of-range address; pulses with `done`

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, CLEAR.
- IDLE: `req_ready`=1. On `req_valid && req_ready`:
  - `req_clr`=1 → CLEAR.
  - Otherwise capture addr and data → SETUP.
- SETUP (1 cycle): `latch_d` = captured data; `latch_en` = 0.
- PULSE (EN_CYCLES cycles): `latch_en[addr]` = 1, all other enables 0; `latch_d` held.
- HOLD (HOLD_CYCLES cycles): `latch_en` = 0; `latch_d` held. Then → IDLE with `done` = 1.
- CLEAR (EN_CYCLES cycles): `latch_rstn` = 0, `latch_en` = 0. Then → IDLE with `done` = 1.
- Out-of-range address (`addr ≥ NUM_WORDS`):
  - The request is accepted and the full sequence runs.
  - `latch_en` stays 0 throughout.
  - `err` = 1 in the same cycle as `done`.
- `req_clr` has priority over the address when both are meaningful.
- `latch_d` keeps its last value while IDLE. It changes only on entry to SETUP.
- At most one `latch_en` bit is high in any cycle.
- `latch_en` and `latch_rstn=0` are never asserted together.
- A single down-counter, sized for max(EN_CYCLES, HOLD_CYCLES), times PULSE, HOLD and CLEAR.

## Timing
- All outputs are registered.
- Reset values:
  - `req_ready`=0, `busy`=0, `done`=0, `err`=0
  - `latch_en`=0, `latch_d`=0
  - `latch_rstn`=0, so the bank is cleared while reset is held
- First cycle after `rstn` rises: `req_ready`=1, `latch_rstn`=1.
- Write accepted at edge k:
  - SETUP in cycle k+1.
  - Enable high in cycles k+2 .. k+1+EN_CYCLES.
  - HOLD follows.
  - `done` in cycle k+2+EN_CYCLES+HOLD_CYCLES; `req_ready` is already 1 in that cycle.
- Back-to-back: a request accepted in the `done` cycle is legal. Defaults give one write per 4 cycles.
- Clear accepted at k: `latch_rstn`=0 in cycles k+1 .. k+EN_CYCLES; `done` in k+1+EN_CYCLES.
- `req_ready` drops in the cycle after acceptance. Requests presented while it is 0 are not taken.
- Reset mid-operation:
  - At the next edge with `rstn`=0, all enables drop and the FSM returns to IDLE.
  - The in-flight write is abandoned; no `done` or `err`.
  - `latch_rstn`=0 clears the bank.

## Structure
- Package `fpu_latch_pkg` holds:
  - state encoding localparams (IDLE=0 … CLEAR=4)
  - the state width
  - the counter-width function
- One natural sub-module: `latch_en_decoder`, which takes addr and produces a one-hot NUM_WORDS vector plus an out-of-range flag. It is combinational, and its output is registered in the controller.

## Test plan
- Reset held 3 cycles, then released:
  - During reset: `latch_rstn`=0, `latch_en`=0, `req_ready`=0.
  - Next cycle: `req_ready`=1, `latch_rstn`=1.
- Write addr=5, data=32'hDEADBEEF accepted at k:
  - `latch_d`=DEADBEEF from k+1.
  - `latch_en`=8'b0010_0000 only in k+2.
  - `done`=1 at k+4, `err`=0.
- Two back-to-back writes (addr 1, then addr 2, second accepted in the first's `done` cycle) → enables are never overlapping, never adjacent across words, and `latch_d` is stable while either enable is high.
- EN_CYCLES=3, HOLD_CYCLES=2, write addr=0 → `latch_en[0]` high exactly 3 cycles, `done` at k+7.
- Write addr=9 with NUM_WORDS=8 and ADDR_W=4 → `latch_en`=0 throughout; `done`=1 and `err`=1 at k+4.
- Clear request, then a `rstn` pulse asserted during the PULSE of a write:
  - Clear gives `latch_rstn`=0 for EN_CYCLES cycles, then `done`.
  - The reset drops `latch_en` at the next edge and gives no `done`.
